// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder accumulator stage.
// Holds the FSM state encoding and the default width constants used by
// rca_accumulator and its bench.
package rca_pkg;

    localparam int RCA_WIDTH     = 6;
    localparam int RCA_ACC_W     = 12;
    localparam int RCA_MAX_TERMS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rca_accumulator.sv
// rca_accumulator
//   Downstream stage of the ripple-carry adder. Accepts (WIDTH+1)-bit sums
//   over a valid/ready handshake, accumulates a programmed number of terms
//   into an ACC_W-bit total, and presents the total plus a sticky overflow
//   flag over a second valid/ready handshake.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   start      in   1        begins a run (honoured only in IDLE)
//   num_terms  in   CNT_W    terms in this run, sampled with start
//   in_valid   in   1        in_sum is valid
//   in_ready   out  1        block accepts in_sum (high only in ACCUM)
//   in_sum     in   WIDTH+1  adder result
//   out_valid  out  1        acc_out is final (high only in DONE)
//   out_ready  in   1        consumer takes acc_out
//   acc_out    out  ACC_W    accumulated total, modulo 2^ACC_W
//   overflow   out  1        sticky carry out of the accumulator
//   term_cnt   out  CNT_W    terms accepted so far in the current run
//   busy       out  1        high in ACCUM and DONE
module rca_accumulator
    import rca_pkg::*;
#(
    parameter int WIDTH     = RCA_WIDTH,
    parameter int ACC_W     = RCA_ACC_W,
    parameter int MAX_TERMS = RCA_MAX_TERMS,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_terms,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH:0]     in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               overflow,
    output logic [CNT_W-1:0]   term_cnt,
    output logic               busy
);

    // Zero bits needed to widen in_sum to the ACC_W+1-bit adder.
    localparam int PAD = ACC_W - WIDTH;

    generate
        if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
            $error("rca_accumulator: ACC_W must be at least WIDTH+1");
        end
    endgenerate

    state_t           state_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] term_cnt_reg;
    logic [CNT_W-1:0] target_reg;

    logic [ACC_W:0]   sum_next;
    logic [CNT_W-1:0] target_next;
    logic [CNT_W-1:0] last_idx;

    // Top bit of sum_next is the carry out of the accumulator.
    assign sum_next    = {1'b0, acc_reg} + {{PAD{1'b0}}, in_sum};
    assign target_next = (num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : num_terms;
    assign last_idx    = target_reg - CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            overflow_reg <= 1'b0;
            term_cnt_reg <= '0;
            target_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg      <= '0;
                        overflow_reg <= 1'b0;
                        term_cnt_reg <= '0;
                        target_reg   <= target_next;
                        // A zero-term run has nothing to wait for: report 0 at once.
                        if (num_terms == '0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    // in_ready is tied high in this state, so in_valid alone is a transfer.
                    if (in_valid) begin
                        acc_reg      <= sum_next[ACC_W-1:0];
                        overflow_reg <= overflow_reg | sum_next[ACC_W];
                        term_cnt_reg <= term_cnt_reg + CNT_W'(1);
                        if (term_cnt_reg == last_idx) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state register, so they
    // never glitch on input activity and are mutually exclusive.
    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
    assign acc_out   = acc_reg;
    assign overflow  = overflow_reg;
    assign term_cnt  = term_cnt_reg;

`ifdef FORMAL
    logic [ACC_W-1:0] shadow_sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_sum_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            shadow_sum_reg <= '0;
        end else if (in_valid && in_ready) begin
            shadow_sum_reg <= shadow_sum_reg + ACC_W'(in_sum);
        end
    end

    always_comb begin
        assert (acc_out == shadow_sum_reg);
        assert (!(in_ready && out_valid));
    end
`endif

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed bench for rca_accumulator. Two instances share all inputs: a
// default one (ACC_W=12) and a narrow one (ACC_W=8) used to observe wrap
// and the sticky overflow flag.
module tb_rca_accumulator;
    import rca_pkg::*;

    localparam int WIDTH = 6;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_terms;
    logic             in_valid;
    logic [WIDTH:0]   in_sum;
    logic             out_ready;

    logic             in_ready_a, out_valid_a, overflow_a, busy_a;
    logic [11:0]      acc_a;
    logic [CNT_W-1:0] cnt_a;
    logic             in_ready_b, out_valid_b, overflow_b, busy_b;
    logic [7:0]       acc_b;
    logic [CNT_W-1:0] cnt_b;

    int checks;
    int errors;

    rca_accumulator #(.WIDTH(6), .ACC_W(12), .MAX_TERMS(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum),
        .out_valid(out_valid_a), .out_ready(out_ready), .acc_out(acc_a),
        .overflow(overflow_a), .term_cnt(cnt_a), .busy(busy_a)
    );

    rca_accumulator #(.WIDTH(6), .ACC_W(8), .MAX_TERMS(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum),
        .out_valid(out_valid_b), .out_ready(out_ready), .acc_out(acc_b),
        .overflow(overflow_b), .term_cnt(cnt_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_done_a(input string tag, input int acc, input int ovf, input int cnt);
        check({tag, ".out_valid"}, {31'd0, out_valid_a}, 1);
        check({tag, ".in_ready"},  {31'd0, in_ready_a},  0);
        check({tag, ".acc"},       {20'd0, acc_a},       acc);
        check({tag, ".overflow"},  {31'd0, overflow_a},  ovf);
        check({tag, ".term_cnt"},  {27'd0, cnt_a},       cnt);
    endtask

    task automatic start_run(input int n);
        start     = 1'b1;
        num_terms = CNT_W'(n);
        step();
        start     = 1'b0;
    endtask

    task automatic exit_done();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num_terms = '0;
        in_valid  = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst.acc",       {20'd0, acc_a},       0);
        check("rst.busy",      {31'd0, busy_a},      0);
        check("rst.in_ready",  {31'd0, in_ready_a},  0);
        check("rst.out_valid", {31'd0, out_valid_a}, 0);
        check("rst.overflow",  {31'd0, overflow_a},  0);
        rst = 1'b0;
        step();
        check("idle.busy", {31'd0, busy_a}, 0);

        // 1: three terms 10+20+127 = 157
        start_run(3);
        check("t1.in_ready", {31'd0, in_ready_a}, 1);
        check("t1.busy",     {31'd0, busy_a},     1);
        check("t1.cnt0",     {27'd0, cnt_a},      0);
        in_valid = 1'b1;
        in_sum = 7'd10;  step();
        check("t1.acc1", {20'd0, acc_a}, 10);
        in_sum = 7'd20;  step();
        check("t1.early_valid", {31'd0, out_valid_a}, 0);
        check("t1.cnt2",        {27'd0, cnt_a},       2);
        in_sum = 7'd127; step();
        in_valid = 1'b0;
        check_done_a("t1", 157, 0, 3);
        check("t1b.acc", {24'd0, acc_b}, 157);
        exit_done();
        check("t1.exit_valid", {31'd0, out_valid_a}, 0);
        check("t1.exit_busy",  {31'd0, busy_a},      0);
        check("t1.hold_acc",   {20'd0, acc_a},       157);

        // 2: 127+127+10 = 264; wraps to 8 with overflow in the 8-bit instance
        start_run(3);
        in_valid = 1'b1;
        in_sum = 7'd127; step();
        check("t2b.ovf_clear", {31'd0, overflow_b}, 0);
        in_sum = 7'd127; step();
        in_sum = 7'd10;  step();
        in_valid = 1'b0;
        check("t2b.acc",       {24'd0, acc_b},       8);
        check("t2b.overflow",  {31'd0, overflow_b},  1);
        check("t2b.out_valid", {31'd0, out_valid_b}, 1);
        check_done_a("t2", 264, 0, 3);
        exit_done();
        check("t2b.ovf_hold", {31'd0, overflow_b}, 1);

        // 3: zero-term run goes straight to DONE with a zero total
        start_run(0);
        check_done_a("t3", 0, 0, 0);
        check("t3.busy",     {31'd0, busy_a},     1);
        check("t3b.ovf_clr", {31'd0, overflow_b}, 0);
        exit_done();
        check("t3.exit_busy", {31'd0, busy_a}, 0);

        // 4: DONE holds under out_ready low despite in_valid and start activity
        start_run(1);
        in_valid = 1'b1;
        in_sum = 7'd50; step();
        in_sum = 7'd33;
        num_terms = 5'd2;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            step();
            check_done_a($sformatf("t4.hold%0d", i), 50, 0, 1);
        end
        // start present in the exit cycle must be ignored
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("t4.exit_valid", {31'd0, out_valid_a}, 0);
        check("t4.exit_busy",  {31'd0, busy_a},      0);
        check("t4.exit_ready", {31'd0, in_ready_a},  0);
        check("t4.exit_acc",   {20'd0, acc_a},       50);

        // 5: asynchronous reset midway through a four-term run
        start_run(4);
        in_valid = 1'b1;
        in_sum = 7'd7; step();
        in_sum = 7'd8; step();
        in_valid = 1'b0;
        check("t5.acc_pre", {20'd0, acc_a}, 15);
        check("t5.cnt_pre", {27'd0, cnt_a}, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t5.rst_acc",   {20'd0, acc_a},       0);
        check("t5.rst_cnt",   {27'd0, cnt_a},       0);
        check("t5.rst_busy",  {31'd0, busy_a},      0);
        check("t5.rst_ready", {31'd0, in_ready_a},  0);
        check("t5.rst_valid", {31'd0, out_valid_a}, 0);
        step();
        rst = 1'b0;
        step();
        start_run(2);
        in_valid = 1'b1;
        in_sum = 7'd5; step();
        in_sum = 7'd6; step();
        in_valid = 1'b0;
        check_done_a("t5", 11, 0, 2);
        exit_done();

        // 6: num_terms=20 clamps to 16; random in_valid gaps
        start_run(20);
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                step();
            end
            check($sformatf("t6.gap_cnt%0d", i), {27'd0, cnt_a}, i);
            check($sformatf("t6.gap_acc%0d", i), {20'd0, acc_a}, i * 127);
            in_valid = 1'b1;
            in_sum = 7'd127;
            step();
        end
        check_done_a("t6", 2032, 0, 16);
        check("t6b.acc",      {24'd0, acc_b},      240);
        check("t6b.overflow", {31'd0, overflow_b}, 1);
        // in_valid stays high in DONE: no further terms may be absorbed
        for (int i = 0; i < 3; i++) begin
            step();
            check_done_a($sformatf("t6.post%0d", i), 2032, 0, 16);
        end
        in_valid = 1'b0;
        exit_done();
        check("t6.exit_valid", {31'd0, out_valid_a}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
